btn_debounce_tick: RTL and testbench

Debounces the game's push-buttons using the slow divided clock from the ripple clock divider as a timing base.
- TICK_SRC is sampled as data in the CLKIN domain. It is never used as a clock.
- A rising edge on TICK_SRC becomes a one-cycle TICK enable.
- Per-button state machines qualify stable levels and emit one-cycle press/release strobes.
- Sits between the divider and the game-control FSM.

---
 rtl/game_pkg.sv | 14 +
 rtl/debounce_chan.sv | 100 ++++++++++
 rtl/btn_debounce_tick.sv | 65 ++++++
 tb/tb_btn_debounce_tick.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the push-button front end: per-button FSM state
// encoding and the debounce counter width.
package game_pkg;

  localparam int DEB_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ARM_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_ARM_RELEASE = 2'd3
  } btn_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchronizer, qualification FSM counting shared
// ticks, registered debounced level and one-cycle press/release strobes.
module debounce_chan
  import game_pkg::*;
#(
  parameter int DEB_TICKS = 4
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_LIM = DEB_CNT_W'(DEB_TICKS);

  logic                 sync1_q;
  logic                 sync2_q;
  btn_state_e           state_q;
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] cnt_inc;
  logic                 level_q;
  logic                 press_q;
  logic                 release_q;

  assign cnt_inc = cnt_q + DEB_CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      // An input reversal is tested before the tick so it always wins.
      case (state_q)
        ST_IDLE: begin
          if (sync2_q) begin
            state_q <= ST_ARM_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_ARM_PRESS: begin
          if (!sync2_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (tick_i) begin
            if (cnt_inc == DEB_LIM) begin
              state_q <= ST_PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_PRESSED: begin
          if (!sync2_q) begin
            state_q <= ST_ARM_RELEASE;
            cnt_q   <= '0;
          end
        end
        ST_ARM_RELEASE: begin
          if (sync2_q) begin
            state_q <= ST_PRESSED;
            cnt_q   <= '0;
          end else if (tick_i) begin
            if (cnt_inc == DEB_LIM) begin
              state_q   <= ST_IDLE;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce_tick.sv
// Button debouncer: turns the divided clock (sampled as data) into a one-cycle
// tick and runs N_BTN independent debounce channels off that shared tick.
module btn_debounce_tick
  import game_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int DEB_TICKS = 4
) (
  input  logic             CLKIN,
  input  logic             SCLR,
  input  logic             TICK_SRC,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic             TICK,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE
);

  logic       tsrc_sync1_q;
  logic       tsrc_sync2_q;
  logic       tsrc_prev_q;
  logic [1:0] tsrc_vld_q;
  logic       tsrc_armed_q;
  logic       tick_q;

  // tsrc_vld_q marks when sync2 holds a real sample; a genuine low must be
  // seen before any rise counts, so a source already high at reset is ignored.
  always_ff @(posedge CLKIN) begin
    if (SCLR) begin
      tsrc_sync1_q <= 1'b0;
      tsrc_sync2_q <= 1'b0;
      tsrc_prev_q  <= 1'b0;
      tsrc_vld_q   <= 2'b00;
      tsrc_armed_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      tsrc_sync1_q <= TICK_SRC;
      tsrc_sync2_q <= tsrc_sync1_q;
      tsrc_prev_q  <= tsrc_sync2_q;
      tsrc_vld_q   <= {tsrc_vld_q[0], 1'b1};
      tsrc_armed_q <= tsrc_armed_q | (tsrc_vld_q[1] & ~tsrc_sync2_q);
      tick_q       <= tsrc_sync2_q & ~tsrc_prev_q & tsrc_armed_q;
    end
  end

  assign TICK = tick_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      debounce_chan #(
        .DEB_TICKS(DEB_TICKS)
      ) u_chan (
        .clk_i    (CLKIN),
        .srst_i   (SCLR),
        .tick_i   (tick_q),
        .btn_i    (BTN_IN[gi]),
        .level_o  (BTN_LEVEL[gi]),
        .press_o  (BTN_PRESS[gi]),
        .release_o(BTN_RELEASE[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce_tick.sv
// Scoreboard bench for btn_debounce_tick: stimulus pushes expected tick cycles
// and strobe windows; a negedge monitor pops and compares DUT events.
module tb_btn_debounce_tick;

  logic       clk = 1'b0;
  logic       SCLR;
  logic       TICK_SRC;
  logic [1:0] BTN_IN;
  logic       TICK;
  logic [1:0] BTN_LEVEL;
  logic [1:0] BTN_PRESS;
  logic [1:0] BTN_RELEASE;

  always #5 clk = ~clk;

  btn_debounce_tick #(
    .N_BTN(2),
    .DEB_TICKS(4)
  ) dut (
    .CLKIN      (clk),
    .SCLR       (SCLR),
    .TICK_SRC   (TICK_SRC),
    .BTN_IN     (BTN_IN),
    .TICK       (TICK),
    .BTN_LEVEL  (BTN_LEVEL),
    .BTN_PRESS  (BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE)
  );

  typedef struct {
    logic [1:0] press;
    logic [1:0] rel;
    int         lo;
    int         hi;
    string      name;
  } bexp_t;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    gen_cnt  = 0;
  logic  gen_en   = 1'b0;
  int    tq[$];
  bexp_t bq[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // TICK_SRC: toggles every 8 cycles; each rise should give TICK 3 edges later.
  initial forever begin
    @(negedge clk);
    if (gen_en) begin
      gen_cnt++;
      if (gen_cnt == 8) begin
        gen_cnt  = 0;
        TICK_SRC = ~TICK_SRC;
        if (TICK_SRC) tq.push_back(cyc + 3);
      end
    end
  end

  initial forever begin : monitor
    int    e;
    bexp_t b;
    @(negedge clk);
    if (tq.size() > 0 && tq[0] < cyc) begin
      checks++; failures++;
      e = tq.pop_front();
      $display("FAIL tick_missed cyc=%0d actual=none required_cyc=%0d", cyc, e);
    end
    if (TICK === 1'b1) begin
      checks++;
      if (tq.size() == 0) begin
        failures++;
        $display("FAIL tick_unexpected cyc=%0d actual=1 required=0", cyc);
      end else begin
        e = tq.pop_front();
        if (e != cyc) begin
          failures++;
          $display("FAIL tick_timing actual_cyc=%0d required_cyc=%0d", cyc, e);
        end else
          $display("tick ok cyc=%0d", cyc);
      end
    end
    if (bq.size() > 0 && bq[0].hi < cyc) begin
      checks++; failures++;
      b = bq.pop_front();
      $display("FAIL %s missed cyc=%0d actual=none required_window=[%0d,%0d]", b.name, cyc, b.lo, b.hi);
    end
    if (BTN_PRESS !== 2'b00 || BTN_RELEASE !== 2'b00) begin
      checks++;
      if (bq.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected cyc=%0d actual press=%b release=%b required none", cyc, BTN_PRESS, BTN_RELEASE);
      end else begin
        b = bq.pop_front();
        if (BTN_PRESS !== b.press || BTN_RELEASE !== b.rel || cyc < b.lo || cyc > b.hi) begin
          failures++;
          $display("FAIL %s actual press=%b release=%b cyc=%0d required press=%b release=%b window=[%0d,%0d]",
                   b.name, BTN_PRESS, BTN_RELEASE, cyc, b.press, b.rel, b.lo, b.hi);
        end else
          $display("%s ok press=%b release=%b cyc=%0d", b.name, BTN_PRESS, BTN_RELEASE, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else
      $display("%s ok value=%0d", name, act);
  endtask

  // Input changed at this negedge (cyc=c): counting starts at c+3, so the
  // 4th counted tick lands the strobe in [c+52, c+67] for a 16-cycle tick.
  task automatic expect_btn(input string name, input logic [1:0] p, input logic [1:0] r);
    bexp_t b;
    b.press = p; b.rel = r; b.lo = cyc + 52; b.hi = cyc + 67; b.name = name;
    bq.push_back(b);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (TICK === 1'b1) seen = 1;
    end
    chk("first_tick_seen", int'(seen), 1);
  endtask

  initial begin
    int    c;
    bexp_t b;
    SCLR = 1'b1; TICK_SRC = 1'b1; BTN_IN = 2'b00;
    wait_cyc(3);
    chk("rst_tick", int'(TICK), 0);
    chk("rst_level", int'(BTN_LEVEL), 0);
    chk("rst_press", int'(BTN_PRESS), 0);
    chk("rst_release", int'(BTN_RELEASE), 0);
    SCLR = 1'b0;
    wait_cyc(24);                 // TICK_SRC high since reset: no tick allowed
    gen_en = 1'b1;
    wait_tick(40);

    // clean press on channel 0
    wait_cyc(2);
    BTN_IN[0] = 1'b1; expect_btn("press0_clean", 2'b01, 2'b00);
    wait_cyc(72);
    chk("level_after_press", int'(BTN_LEVEL), 1);
    chk("press0_consumed", bq.size(), 0);

    // release glitch: low for exactly 3 ticks, then restored
    BTN_IN[0] = 1'b0; wait_cyc(48); BTN_IN[0] = 1'b1;
    wait_cyc(80);
    chk("level_after_glitch", int'(BTN_LEVEL), 1);
    BTN_IN[0] = 1'b0; expect_btn("release0_sustained", 2'b00, 2'b01);
    wait_cyc(72);
    chk("level_after_release", int'(BTN_LEVEL), 0);
    chk("release0_consumed", bq.size(), 0);

    // bounce: toggle every 5 cycles, then hold high
    for (int i = 0; i < 12; i++) begin
      BTN_IN[0] = ~BTN_IN[0];
      wait_cyc(5);
    end
    BTN_IN[0] = 1'b1; expect_btn("press0_after_bounce", 2'b01, 2'b00);
    wait_cyc(72);
    chk("level_after_bounce", int'(BTN_LEVEL), 1);
    BTN_IN[0] = 1'b0; expect_btn("release0_after_bounce", 2'b00, 2'b01);
    wait_cyc(72);
    chk("level_released_again", int'(BTN_LEVEL), 0);

    // reset after 3 counted ticks (at c+3, c+19, c+35); restart from c+37
    @(posedge TICK_SRC);
    BTN_IN[0] = 1'b1; c = cyc;
    b.press = 2'b01; b.rel = 2'b00; b.lo = c + 89; b.hi = c + 104; b.name = "press0_after_midrst";
    bq.push_back(b);
    wait_cyc(36);
    SCLR = 1'b1; wait_cyc(1); SCLR = 1'b0;
    chk("level_after_midrst", int'(BTN_LEVEL), 0);
    wait_cyc(72);
    chk("level_fresh_count", int'(BTN_LEVEL), 1);
    chk("midrst_consumed", bq.size(), 0);

    // both channels together
    BTN_IN = 2'b00; expect_btn("release0_before_dual", 2'b00, 2'b01);
    wait_cyc(72);
    BTN_IN = 2'b11; expect_btn("press_dual", 2'b11, 2'b00);
    wait_cyc(72);
    chk("level_dual", int'(BTN_LEVEL), 3);
    BTN_IN = 2'b00; expect_btn("release_dual", 2'b00, 2'b11);
    wait_cyc(72);
    chk("level_dual_released", int'(BTN_LEVEL), 0);

    // channel 1 drop lands on the 4th tick: reversal wins, no press
    @(posedge TICK_SRC);
    BTN_IN[1] = 1'b1;
    wait_cyc(49);
    BTN_IN[1] = 1'b0;
    wait_cyc(40);
    chk("level_coincident", int'(BTN_LEVEL), 0);
    chk("coincident_no_strobe", bq.size(), 0);
    BTN_IN[1] = 1'b1; expect_btn("press1_after_coincident", 2'b10, 2'b00);
    wait_cyc(72);
    chk("level_ch1", int'(BTN_LEVEL), 2);

    gen_en = 1'b0;
    wait_cyc(6);
    chk("tick_queue_drained", tq.size(), 0);
    chk("btn_queue_drained", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
